// File: rtl/adsr_env_if.sv
// adsr_env_if: control/envelope bundle between a voice controller and adsr_env.
// Latency: wires only, no storage.
// Backpressure: none; the envelope advances only on sample ticks (i_ce).
interface adsr_env_if #(
   parameter int W  = 16,
   parameter int RW = 16
);
   logic          i_ce;
   logic          i_gate;
   logic [RW-1:0] i_attack;
   logic [RW-1:0] i_decay;
   logic [W-1:0]  i_sustain;
   logic [RW-1:0] i_release;
   logic [W-1:0]  o_env;
   logic [2:0]    o_state;
   logic          o_active;
   logic          o_done;

   // Controller side: drives tick, gate and rates, observes the envelope.
   modport master (
      output i_ce, i_gate, i_attack, i_decay, i_sustain, i_release,
      input  o_env, o_state, o_active, o_done
   );

   // Envelope generator side.
   modport slave (
      input  i_ce, i_gate, i_attack, i_decay, i_sustain, i_release,
      output o_env, o_state, o_active, o_done
   );
endinterface

// File: rtl/adsr_env.sv
// adsr_env: linear ADSR envelope generator for one voice, at most one step per sample tick.
// Latency: ENV/STATE update on the CE clock edge, visible the following cycle; DONE pulses one cycle.
// Backpressure: none; all state holds while CE is low.
module adsr_env #(
   parameter int W  = 16,
   parameter int RW = 16
) (
   input logic       i_clk,
   input logic       i_rst,
   adsr_env_if.slave bus
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ATTACK  = 3'd1;
   localparam logic [2:0] S_DECAY   = 3'd2;
   localparam logic [2:0] S_SUSTAIN = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;

   // One bit wider than the widest operand so sums/compares never wrap.
   localparam int SW = ((W > RW) ? W : RW) + 1;
   localparam logic [SW-1:0] MAX_X = SW'({W{1'b1}});

   logic [W-1:0] r_env;
   logic [2:0]   r_state;
   logic         r_active;
   logic         r_done;
   logic         r_gq;

   logic          w_rise;
   logic          w_fall;
   logic [SW-1:0] w_env_x;
   logic [SW-1:0] w_att_x;
   logic [SW-1:0] w_dec_x;
   logic [SW-1:0] w_rel_x;
   logic [SW-1:0] w_sus_x;
   logic [W-1:0]  w_env_nxt;
   logic [2:0]    w_state_nxt;
   logic          w_done_nxt;

   assign w_rise  = bus.i_gate & ~r_gq;
   assign w_fall  = ~bus.i_gate & r_gq;
   assign w_env_x = SW'(r_env);
   assign w_att_x = SW'(bus.i_attack);
   assign w_dec_x = SW'(bus.i_decay);
   assign w_rel_x = SW'(bus.i_release);
   assign w_sus_x = SW'(bus.i_sustain);

   // Next envelope/state for a tick: gate edges take priority over the per-state step.
   always_comb begin
      w_env_nxt   = r_env;
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      if (w_rise) begin
         // Legato retrigger: restart attack from the current level.
         w_state_nxt = S_ATTACK;
      end else if (w_fall && (r_state == S_ATTACK || r_state == S_DECAY ||
                              r_state == S_SUSTAIN)) begin
         w_state_nxt = S_RELEASE;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_env_nxt = '0;
            end
            S_ATTACK: begin
               if (bus.i_attack == '0 || (w_env_x + w_att_x) >= MAX_X) begin
                  w_env_nxt   = {W{1'b1}};
                  w_state_nxt = S_DECAY;
               end else begin
                  w_env_nxt = W'(w_env_x + w_att_x);
               end
            end
            S_DECAY: begin
               // Also catches ENV below SUSTAIN, which snaps up to the sustain level.
               if (bus.i_decay == '0 || w_env_x <= (w_sus_x + w_dec_x)) begin
                  w_env_nxt   = bus.i_sustain;
                  w_state_nxt = S_SUSTAIN;
               end else begin
                  w_env_nxt = W'(w_env_x - w_dec_x);
               end
            end
            S_SUSTAIN: begin
               // Track live sustain changes; a gate that is already low still releases.
               w_env_nxt = bus.i_sustain;
               if (!bus.i_gate) begin
                  w_state_nxt = S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (bus.i_release == '0 || w_env_x <= w_rel_x) begin
                  w_env_nxt   = '0;
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_env_nxt = W'(w_env_x - w_rel_x);
               end
            end
            default: begin
               w_env_nxt   = '0;
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Envelope registers advance only on sample ticks; DONE is cleared on every non-tick cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_env    <= '0;
         r_state  <= S_IDLE;
         r_active <= 1'b0;
         r_done   <= 1'b0;
         r_gq     <= 1'b0;
      end else if (bus.i_ce) begin
         r_gq     <= bus.i_gate;
         r_env    <= w_env_nxt;
         r_state  <= w_state_nxt;
         r_active <= (w_state_nxt != S_IDLE);
         r_done   <= w_done_nxt;
      end else begin
         r_done <= 1'b0;
      end
   end

   assign bus.o_env    = r_env;
   assign bus.o_state  = r_state;
   assign bus.o_active = r_active;
   assign bus.o_done   = r_done;
endmodule

// File: tb/tb_adsr_env.sv
// tb_adsr_env: scoreboard bench for adsr_env with directed scenarios then random ticks.
// Expected results come from a tick-level reference model and are popped by a monitor.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_adsr_env;
   localparam int W    = 16;
   localparam int RW   = 16;
   localparam int MAXV = 65535;

   typedef struct {
      int env;
      int state;
      bit done;
   } exp_t;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;

   adsr_env_if #(.W(W), .RW(RW)) bus ();

   adsr_env #(.W(W), .RW(RW)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 i_clk = ~i_clk;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   m_env = 0;
   int   m_state = 0;
   bit   m_gq = 1'b0;
   int   last_env = 0;
   int   last_state = 0;
   bit   ce_seen = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one sample tick of the envelope, from the current inputs.
   task automatic model_tick();
      int  a, d, s, r;
      bit  g, rise, fall, done;
      exp_t e;
      a = int'(bus.i_attack); d = int'(bus.i_decay);
      s = int'(bus.i_sustain); r = int'(bus.i_release);
      g = bus.i_gate;
      rise = g && !m_gq;
      fall = !g && m_gq;
      done = 1'b0;
      if (rise) m_state = 1;
      else if (fall && m_state >= 1 && m_state <= 3) m_state = 4;
      else begin
         if (m_state == 0) m_env = 0;
         else if (m_state == 1) begin
            if (a == 0 || m_env + a >= MAXV) begin m_env = MAXV; m_state = 2; end
            else m_env = m_env + a;
         end else if (m_state == 2) begin
            if (d == 0 || m_env <= s + d) begin m_env = s; m_state = 3; end
            else m_env = m_env - d;
         end else if (m_state == 3) begin
            m_env = s;
            if (!g) m_state = 4;
         end else begin
            if (r == 0 || m_env <= r) begin m_env = 0; m_state = 0; done = 1'b1; end
            else m_env = m_env - r;
         end
      end
      m_gq = g;
      e.env = m_env; e.state = m_state; e.done = done;
      q.push_back(e);
   endtask

   // Issue one CE tick (called on a falling edge), then idle cycles with CE low.
   task automatic do_tick(input int idle);
      bus.i_ce = 1'b1;
      model_tick();
      @(negedge i_clk);
      bus.i_ce = 1'b0;
      repeat (idle) @(negedge i_clk);
   endtask

   // Direct check of the current DUT outputs against scenario constants.
   task automatic chk_now(input string name, input int env, input int state);
      check({name, "_env"}, int'(bus.o_env), env);
      check({name, "_state"}, int'(bus.o_state), state);
      check({name, "_active"}, int'(bus.o_active), int'(state != 0));
   endtask

   // Asynchronous reset pulse asserted away from any clock edge.
   task automatic pulse_reset();
      @(posedge i_clk);
      #2 i_rst = 1'b1;
      #1;
      check("async_rst_env", int'(bus.o_env), 0);
      check("async_rst_state", int'(bus.o_state), 0);
      check("async_rst_done", int'(bus.o_done), 0);
      check("async_rst_active", int'(bus.o_active), 0);
      m_env = 0; m_state = 0; m_gq = 1'b0;
      last_env = 0; last_state = 0;
      repeat (2) @(negedge i_clk);
      @(posedge i_clk);
      #2 i_rst = 1'b0;
      @(negedge i_clk);
   endtask

   function automatic logic [15:0] rnd_rate();
      case ($urandom_range(0, 3))
         0:       return 16'h0000;
         1:       return 16'($urandom_range(1, 16'h0800));
         2:       return 16'($urandom_range(16'h1000, 16'h8000));
         default: return 16'($urandom);
      endcase
   endfunction

   always @(posedge i_clk) ce_seen = bus.i_ce && !i_rst;

   // Monitor: after a tick compare against the scoreboard, otherwise outputs must hold.
   always @(negedge i_clk) begin
      exp_t e;
      if (ce_seen) begin
         if (q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            e = q.pop_front();
            check("tick_env", int'(bus.o_env), e.env);
            check("tick_state", int'(bus.o_state), e.state);
            check("tick_active", int'(bus.o_active), int'(e.state != 0));
            check("tick_done", int'(bus.o_done), int'(e.done));
            last_env = e.env;
            last_state = e.state;
         end
      end else if (!i_rst) begin
         check("hold_done", int'(bus.o_done), 0);
         check("hold_env", int'(bus.o_env), last_env);
         check("hold_state", int'(bus.o_state), last_state);
      end
   end

   initial begin
      bus.i_ce = 1'b0; bus.i_gate = 1'b0;
      bus.i_attack = 16'h4000; bus.i_decay = 16'h1000;
      bus.i_sustain = 16'hC000; bus.i_release = 16'h4000;
      repeat (3) @(negedge i_clk);
      chk_now("reset", 0, 0);
      check("reset_done", int'(bus.o_done), 0);
      i_rst = 1'b0;
      @(negedge i_clk);

      // Attack
      bus.i_gate = 1'b1;
      do_tick(3);
      chk_now("attack_rise", 0, 1);
      repeat (4) do_tick(3);
      chk_now("attack_top", 16'hFFFF, 2);

      // Decay, with a long CE-low hold in the middle
      do_tick(3);
      repeat (50) @(negedge i_clk);
      chk_now("decay_hold", 16'hEFFF, 2);
      repeat (3) do_tick(3);
      chk_now("sustain", 16'hC000, 3);
      bus.i_sustain = 16'hA000;
      do_tick(3);
      chk_now("sustain_live", 16'hA000, 3);
      bus.i_sustain = 16'hC000;
      do_tick(3);

      // Gate glitch entirely between ticks is invisible
      bus.i_gate = 1'b0; @(negedge i_clk);
      bus.i_gate = 1'b1; @(negedge i_clk);
      do_tick(3);
      chk_now("glitch", 16'hC000, 3);

      // Release
      bus.i_gate = 1'b0;
      do_tick(3);
      chk_now("rel_fall", 16'hC000, 4);
      repeat (3) do_tick(3);
      chk_now("rel_end", 0, 0);

      // Retrigger during release at 0x8000
      bus.i_gate = 1'b1; do_tick(1);
      bus.i_attack = 16'h0000; do_tick(1);
      bus.i_decay = 16'h0000; do_tick(1);
      bus.i_gate = 1'b0; do_tick(1);
      do_tick(1);
      chk_now("pre_retrig", 16'h8000, 4);
      bus.i_gate = 1'b1;
      bus.i_attack = 16'h4000;
      do_tick(1);
      chk_now("retrig", 16'h8000, 1);
      do_tick(1);
      chk_now("retrig_step", 16'hC000, 1);

      // Instant rates
      bus.i_gate = 1'b0; bus.i_release = 16'h0000; bus.i_sustain = 16'h1234;
      do_tick(0); do_tick(0);
      bus.i_attack = 16'h0000; bus.i_decay = 16'h0000;
      bus.i_gate = 1'b1;
      do_tick(0); do_tick(0);
      chk_now("inst_attack", 16'hFFFF, 2);
      do_tick(0);
      chk_now("inst_decay", 16'h1234, 3);
      bus.i_gate = 1'b0;
      do_tick(0); do_tick(0);
      chk_now("inst_release", 0, 0);

      // Reset mid-attack
      bus.i_attack = 16'h0100; bus.i_gate = 1'b1;
      repeat (3) do_tick(1);
      chk_now("mid_attack", 16'h0200, 1);
      pulse_reset();

      // Random phase
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0) bus.i_gate = ~bus.i_gate;
         if ($urandom_range(0, 3) == 0) bus.i_attack = rnd_rate();
         if ($urandom_range(0, 3) == 0) bus.i_decay = rnd_rate();
         if ($urandom_range(0, 3) == 0) bus.i_release = rnd_rate();
         if ($urandom_range(0, 7) == 0) bus.i_sustain = 16'($urandom);
         do_tick($urandom_range(0, 3));
      end

      repeat (4) @(negedge i_clk);
      check("sb_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/adsr_env.md
Name: adsr_env

Overview:
- Linear ADSR (attack/decay/sustain/release) envelope generator for one synth voice.
- Sits directly downstream of the sample-rate tick counter: that counter's CO output drives this block's CE input.
- The envelope advances by at most one step per sample tick.
- ENV feeds the voice amplitude multiplier. STATE, ACTIVE and DONE feed the voice allocator.

Parameters:
- W, 16, envelope and sustain-level width; full scale MAX = 2^W-1.
- RW, 16, width of the per-tick rate inputs ATTACK, DECAY and RELEASE.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- CE  input  1  sample tick, one CLK wide (driven by the tick counter's CO); all envelope/state updates are qualified by CE.
- GATE  input  1  note on/off level.
- ATTACK  input  RW  attack increment added per tick; 0 = instant.
- DECAY  input  RW  decay decrement per tick; 0 = instant.
- SUSTAIN  input  W  sustain level.
- RELEASE  input  RW  release decrement per tick; 0 = instant.
- ENV  output  W  envelope level (registered).
- STATE  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4 (registered).
- ACTIVE  output  1  registered; equals (STATE != IDLE).
- DONE  output  1  one-CLK pulse when RELEASE reaches 0.

Behaviour:
- Reset: RST=1 asynchronously forces ENV=0, STATE=IDLE, ACTIVE=0, DONE=0 and the gate history register gq=0. This applies at any point, including mid-envelope.
- CE=0: all registers hold, and DONE=0.
- Gate sampling: GATE is sampled only on CE cycles.
  - rise = GATE & ~gq; fall = ~GATE & gq.
  - gq <= GATE on every CE cycle.
  - GATE changes between ticks are seen only at the next tick; a pulse shorter than one tick period may be missed.
- Latency: ENV/STATE change on the CLK edge where CE=1 and are visible in the following cycle.
- Priority on a CE cycle (first match wins):
  1. rise: STATE <= ATTACK, ENV unchanged. This applies from any state, including RELEASE and ATTACK itself. Legato: no reset of ENV to 0.
  2. fall with STATE in {ATTACK, DECAY, SUSTAIN}: STATE <= RELEASE, ENV unchanged.
  3. Otherwise, apply the per-state step below.
- Per-state step (arithmetic in W+1 bits, no wrap):
  - IDLE: ENV <= 0.
  - ATTACK: if ATTACK==0 or ENV+ATTACK >= MAX, then ENV <= MAX and STATE <= DECAY; else ENV <= ENV+ATTACK.
  - DECAY: if DECAY==0 or ENV <= SUSTAIN+DECAY, then ENV <= SUSTAIN and STATE <= SUSTAIN; else ENV <= ENV-DECAY. This also covers ENV < SUSTAIN, which snaps ENV up to SUSTAIN.
  - SUSTAIN: ENV <= SUSTAIN (follows live changes to SUSTAIN). If GATE=0 with no fall, i.e. GATE was already low, STATE <= RELEASE.
  - RELEASE: if RELEASE==0 or ENV <= RELEASE, then ENV <= 0, STATE <= IDLE, DONE <= 1 for that one cycle; else ENV <= ENV-RELEASE.
- DONE: high exactly one CLK, in the cycle after the CE edge on which RELEASE terminates; otherwise 0.
- Rate inputs and SUSTAIN are sampled live each tick; they may change mid-envelope.

Test Plan:
1. Attack (W=16, ATTACK=0x4000, DECAY=0x1000, SUSTAIN=0xC000): RST pulse, then GATE=1, then CE every 4 CLK.
   - tick1 rise -> STATE=1, ENV=0.
   - ENV then 0x4000, 0x8000, 0xC000, 0xFFFF with STATE=2.
2. Decay (continuing scenario 1):
   - ENV 0xEFFF, 0xDFFF, 0xCFFF, then 0xC000 with STATE=3, ACTIVE=1.
   - Changing SUSTAIN to 0xA000 gives ENV=0xA000 on the next tick.
3. Release (RELEASE=0x4000, SUSTAIN=0xC000): GATE=0.
   - fall tick -> STATE=4, ENV=0xC000.
   - ENV then 0x8000, 0x4000, 0x0000 with STATE=0.
   - DONE=1 for exactly 1 CLK; ACTIVE=0.
4. CE gating and gate pulse:
   - Hold CE=0 for 50 CLK in DECAY -> ENV and STATE unchanged.
   - A GATE pulse between two ticks, returning low before the next tick -> no state change.
5. Retrigger: GATE=1 during RELEASE at ENV=0x8000 -> STATE=1 with ENV=0x8000; next tick ENV=0xC000.
6. Instant rates and reset:
   - ATTACK=DECAY=RELEASE=0 with SUSTAIN=0x1234: ENV goes to 0xFFFF, then 0x1234; after GATE falls, ENV goes to 0, each step on consecutive ticks.
   - Asserting RST mid-ATTACK asynchronously clears ENV=0, STATE=0, DONE=0.
